checkpoint_monitor: RTL
=======================

# checkpoint_monitor

Synthesizable on-chip successor to the checkbit smoke-test watcher. It watches a WIDTH-bit status bus, such as the firmware checkbits on `mprj_io[31:16]`, for a programmable ordered sequence of up to DEPTH signature codes (for example 0xAB60, 0xAB61, …). A prescaled watchdog bounds the whole run, and the block reports pass, timeout or optional out-of-order failure. It sits in the user project area, so self-test status is visible on-chip without a simulation bench.

## Interface
- `WIDTH`, 16: width of the observed code bus and of each table entry.
- `DEPTH`, 4: number of checkpoint table entries (≥1).
- `TICK_CYCLES`, 1000: clock cycles per watchdog tick.
- `TIMEOUT_TICKS`, 30: number of ticks before timeout.
- `clock` in 1: single clock domain; everything is posedge.
- `resetb` in 1: asynchronous, active-low reset.
- `code_i` in WIDTH: observed status code.
- `cfg_we` in 1: table write strobe; honoured only in IDLE.
- `cfg_addr` in clog2(DEPTH): table index.
- `cfg_data` in WIDTH: expected code to write.
- `num_stages` in clog2(DEPTH+1): active sequence length; values above DEPTH are clamped to DEPTH.
- `start` in 1: arm pulse; honoured only in IDLE.
- `clear` in 1: return from PASS/FAIL to IDLE.
- `busy` out 1: high while ARMED.
- `pass` out 1: sticky pass flag.
- `fail` out 1: sticky fail flag.
- `timeout` out 1: the failure cause was the watchdog.
- `order_err` out 1: the failure cause was an out-of-order code.
- `stage` out clog2(DEPTH+1): number of checkpoints matched so far.
- `tick` out 1: one-cycle pulse on every watchdog tick while ARMED.
- `fail_code` out WIDTH: `code_q` captured on an order failure.

## Operation
- States are IDLE, ARMED, PASS and FAIL.
- Reset values: all outputs 0, table entries 0, `code_q` 0, state IDLE.
- `code_i` is registered into `code_q` every cycle, in all states.
- IDLE:
  - `cfg_we` writes `table[cfg_addr] <= cfg_data`.
  - `start` with effective `num_stages` ≥1 → ARMED, clearing `stage`, the prescaler, the tick counter and all flags.
  - `start` with `num_stages` = 0 → PASS.
- ARMED:
  - If `code_q == table[stage]`, `stage` increments.
  - If the incremented `stage` equals `num_stages`, the state goes to PASS with `pass=1` and `busy=0`.
  - One advance per cycle at most. Identical consecutive table entries therefore advance on consecutive cycles.
- Watchdog, ARMED only:
  - The prescaler counts 0..TICK_CYCLES-1. On wrap it pulses `tick` and increments the tick counter.
  - When the tick counter reaches TIMEOUT_TICKS → FAIL with `timeout=1`.
- PASS/FAIL: flags hold. `clear` → IDLE, zeroing flags and `stage`. `start` is ignored.
- `cfg_we`, `start` and `num_stages` changes outside IDLE are ignored. `num_stages` is sampled on `start`.
- Simultaneous final match and timeout: PASS wins.
- Simultaneous `clear` and `start` in PASS/FAIL: `clear` only; `start` must be reissued in IDLE.
- `resetb` low mid-run: immediate asynchronous return to the reset values.

## Timing
- Match latency: `code_i` stable at edge n → `code_q` at n+1 → `stage`/`pass` update at n+2.
- Timeout latency: `fail` and `timeout` assert on the edge that completes tick number TIMEOUT_TICKS, i.e. TICK_CYCLES×TIMEOUT_TICKS cycles after the `start` edge.
- `start` to `busy`: 1 cycle.

## Configuration
- Macro: `CHECKPOINT_MONITOR_ORDER_CHECK_EN`.
- With the macro defined, while ARMED:
  - A failure is detected when `code_q != table[stage]` and `code_q` equals some `table[j]` with stage < j < num_stages.
  - On detection → FAIL with `order_err=1` and `fail_code=code_q`.
  - A match on the current stage takes priority over order detection.
  - Order detection takes priority over a same-cycle timeout.
- Without the macro, out-of-order codes are ignored, and `order_err` and `fail_code` are tied to 0.

## Structure
- Package `checkpoint_monitor_pkg` holds the state encoding (IDLE=0, ARMED=1, PASS=2, FAIL=3) and the default parameter constants.
- Sub-module `checkpoint_wdt` contains the prescaler and tick counter. Its ports are `run` and `clr` in; `tick` and `expired` out.
- The table is a flop array (DEPTH×WIDTH), not a RAM macro.

## Test plan
All scenarios use WIDTH=16, DEPTH=4, TICK_CYCLES=1000 and TIMEOUT_TICKS=30.
- **Nominal pass:** load 0xAB60 and 0xAB61, `num_stages=2`, `start`, drive 0xAB60 then 0xAB61. Expect `stage` 1 then 2, and `pass=1` two cycles after 0xAB61 appears, with `fail=0`.
- **Timeout:** arm and drive 0x0000 throughout. Expect 30 `tick` pulses, then `fail=timeout=1` exactly 30000 cycles after `start`, with `stage=0`.
- **Order check:** with the macro, drive 0xAB61 first. Expect `fail=order_err=1`, `fail_code=0xAB61` and `stage=0`. Without the macro there is no fail, and a following 0xAB60 then 0xAB61 passes.
- **Race:** present the final code so its advance lands on the timeout edge. Expect `pass=1` and `fail=0`.
- **Edge controls:** `start` with `num_stages=0` → `pass=1` next cycle. `cfg_we` while ARMED leaves the table unchanged.
- **Reset and re-arm:** `resetb` pulsed low at `stage=1` → all outputs 0 immediately. After re-arming, the nominal sequence passes.

Source files
------------

// File: rtl/checkpoint_monitor_pkg.sv
// Shared state encoding, default parameter values and width helper for checkpoint_monitor.
package checkpoint_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_PASS  = 2'd2,
    ST_FAIL  = 2'd3
  } state_t;

  localparam int DEF_WIDTH         = 16;
  localparam int DEF_DEPTH         = 4;
  localparam int DEF_TICK_CYCLES   = 1000;
  localparam int DEF_TIMEOUT_TICKS = 30;

  // Never returns zero, so degenerate sizes still give a legal vector width.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/checkpoint_wdt.sv
// Prescaled watchdog: counts TICK_CYCLES clocks per tick while run is high and
// flags the cycle that completes tick number TIMEOUT_TICKS.
module checkpoint_wdt
  import checkpoint_monitor_pkg::*;
#(
  parameter int TICK_CYCLES   = DEF_TICK_CYCLES,
  parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS
) (
  input  logic clock,
  input  logic resetb,
  input  logic run,
  input  logic clr,
  output logic tick,
  output logic expired
);

  localparam int PW = clog2_min1(TICK_CYCLES);
  localparam int TW = clog2_min1(TIMEOUT_TICKS + 1);

  logic [PW-1:0] presc;
  logic [TW-1:0] ticks;

  // Combinational so the owner can act on the same edge that completes the tick.
  assign tick    = run && (presc == PW'(TICK_CYCLES - 1));
  assign expired = tick && (ticks == TW'(TIMEOUT_TICKS - 1));

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      presc <= '0;
      ticks <= '0;
    end else if (clr) begin
      presc <= '0;
      ticks <= '0;
    end else if (run) begin
      if (tick) begin
        presc <= '0;
        ticks <= ticks + TW'(1);
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

endmodule

// File: rtl/checkpoint_monitor.sv
// Watches code_i for an ordered sequence of programmed checkpoint codes under a watchdog.
// Optional out-of-order failure detection: define CHECKPOINT_MONITOR_ORDER_CHECK_EN.
module checkpoint_monitor
  import checkpoint_monitor_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int DEPTH         = DEF_DEPTH,
  parameter int TICK_CYCLES   = DEF_TICK_CYCLES,
  parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS
) (
  input  logic                                clock,
  input  logic                                resetb,
  input  logic [WIDTH-1:0]                    code_i,
  input  logic                                cfg_we,
  input  logic [clog2_min1(DEPTH)-1:0]        cfg_addr,
  input  logic [WIDTH-1:0]                    cfg_data,
  input  logic [$clog2(DEPTH+1)-1:0]          num_stages,
  input  logic                                start,
  input  logic                                clear,
  output logic                                busy,
  output logic                                pass,
  output logic                                fail,
  output logic                                timeout,
  output logic                                order_err,
  output logic [$clog2(DEPTH+1)-1:0]          stage,
  output logic                                tick,
  output logic [WIDTH-1:0]                    fail_code
);

  localparam int AW = clog2_min1(DEPTH);
  localparam int SW = $clog2(DEPTH + 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] code_q;
  logic [WIDTH-1:0] tbl [DEPTH];
  logic [SW-1:0]    num_q, num_clamp, stage_q, stage_inc;
  logic             timeout_q;
  logic             match, last, order_hit;
  logic             wdt_tick, wdt_expired;

  assign num_clamp = (num_stages > SW'(DEPTH)) ? SW'(DEPTH) : num_stages;
  assign stage_inc = stage_q + SW'(1);
  assign match     = (code_q == tbl[stage_q[AW-1:0]]);
  assign last      = match && (stage_inc == num_q);

  checkpoint_wdt #(
    .TICK_CYCLES  (TICK_CYCLES),
    .TIMEOUT_TICKS(TIMEOUT_TICKS)
  ) u_wdt (
    .clock  (clock),
    .resetb (resetb),
    .run    (state_q == ST_ARMED),
    .clr    (state_q != ST_ARMED),
    .tick   (wdt_tick),
    .expired(wdt_expired)
  );

  // State register
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next state: final match beats order failure, which beats timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = (num_clamp == '0) ? ST_PASS : ST_ARMED;
      ST_ARMED: begin
        if (last)             state_d = ST_PASS;
        else if (order_hit)   state_d = ST_FAIL;
        else if (wdt_expired) state_d = ST_FAIL;
      end
      default:  if (clear) state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy = (state_q == ST_ARMED);
    pass = (state_q == ST_PASS);
    fail = (state_q == ST_FAIL);
  end

  assign tick    = wdt_tick;
  assign stage   = stage_q;
  assign timeout = timeout_q;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      code_q    <= '0;
      num_q     <= '0;
      stage_q   <= '0;
      timeout_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
    end else begin
      code_q <= code_i;
      case (state_q)
        ST_IDLE: begin
          if (cfg_we && (int'(cfg_addr) < DEPTH)) tbl[cfg_addr] <= cfg_data;
          if (start) begin
            num_q     <= num_clamp;
            stage_q   <= '0;
            timeout_q <= 1'b0;
          end
        end
        ST_ARMED: begin
          if (match) stage_q <= stage_inc;
          if (!last && !order_hit && wdt_expired) timeout_q <= 1'b1;
        end
        default: begin
          if (clear) begin
            stage_q   <= '0;
            timeout_q <= 1'b0;
          end
        end
      endcase
    end
  end

`ifdef CHECKPOINT_MONITOR_ORDER_CHECK_EN
  logic             order_q;
  logic [WIDTH-1:0] fail_code_q;

  // A code belonging to a later active stage, seen before the current one matched.
  always_comb begin
    order_hit = 1'b0;
    for (int j = 0; j < DEPTH; j++) begin
      if ((j > int'(stage_q)) && (j < int'(num_q)) && (code_q == tbl[j])) order_hit = 1'b1;
    end
    if (match || (state_q != ST_ARMED)) order_hit = 1'b0;
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      order_q     <= 1'b0;
      fail_code_q <= '0;
    end else if ((state_q == ST_IDLE && start) || (state_q != ST_ARMED && state_q != ST_IDLE && clear)) begin
      order_q     <= 1'b0;
      fail_code_q <= '0;
    end else if (state_q == ST_ARMED && !last && order_hit) begin
      order_q     <= 1'b1;
      fail_code_q <= code_q;
    end
  end

  assign order_err = order_q;
  assign fail_code = fail_code_q;
`else
  assign order_hit = 1'b0;
  assign order_err = 1'b0;
  assign fail_code = '0;
`endif

endmodule
